axi_lite_initiator: RTL

Single-outstanding AXI4-Lite initiator (manager) that turns a simple request/response command port into AXI4-Lite read and write transactions. It is the counterpart of the team's AXI MMIO responder controller and drives that block, or any AXI4-Lite subordinate, from a core, a DMA sequencer or a test harness. Responses use `const_pkg::resp_t`.

---
 rtl/const_pkg.sv | 10 +
 rtl/axi_lite_initiator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/const_pkg.sv
// Shared constants and types used across the AXI blocks.
// resp_t encodes the AXI BRESP/RRESP response codes.
package const_pkg;
  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } resp_t;
endpackage

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-Lite manager: turns a request/response command port
// into AXI4-Lite read and write transactions, with every AXI output registered.
module axi_lite_initiator
  import const_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output resp_t               rsp_resp,
  output logic                rsp_write,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  resp_t               rsp_resp_q, rsp_resp_d;
  logic                rsp_write_q, rsp_write_d;
  logic                aw_hs, w_hs;

  assign aw_hs = awvalid_q && awready;
  assign w_hs  = wvalid_q && wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXI_RESP_OKAY;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    case (state_q)
      IDLE: begin
        // req_ready_q is low for the first cycle after reset release
        if (req_ready_q && req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_resp_d  = resp_t'(bresp);
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          rsp_resp_d  = resp_t'(rresp);
          rsp_rdata_d = rdata;
          rsp_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = rsp_write_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign arvalid   = arvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign rready    = rready_q;

endmodule
